baud_gen_prog: RTL

BAUD_GEN_PROG -- requirements
Module: baud_gen_prog

---
 rtl/baud_gen_prog.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/baud_gen_prog.sv
// Programmable baud generator: oversample tick and bit tick from a shadow-loaded divisor.
// Define BAUD_GEN_FRAC_EN to add the fractional phase accumulator (period stretches by one on carry).
module baud_gen_prog #(
    parameter int NB_DIV      = 16,
    parameter int NB_FRAC     = 4,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = 163
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [NB_DIV-1:0] i_div_int,
    input  logic [NB_FRAC-1:0] i_div_frac,
    input  logic              i_div_load,
    output logic              o_tick,
    output logic              o_bit_tick,
    output logic              o_load_pending
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state, state_n;
    logic [NB_DIV-1:0] cnt, cnt_n;
    logic [NB_DIV-1:0] div_act, div_act_n;
    logic [NB_DIV-1:0] div_sh, div_sh_n;
    logic [OS_W-1:0]   os_cnt, os_cnt_n;
    logic              pending_n;
    logic              wrap;
    logic              tick_n;
    logic              bit_n;

`ifdef BAUD_GEN_FRAC_EN
    logic [NB_FRAC-1:0] frac_act, frac_act_n;
    logic [NB_FRAC-1:0] frac_sh, frac_sh_n;
    logic [NB_FRAC-1:0] acc, acc_n;
    logic               extra, extra_n;
    logic               carry;
`else
    logic extra, extra_n, unused_frac;
    assign extra       = 1'b0;
    assign extra_n     = 1'b0;
    assign unused_frac = ^i_div_frac;
`endif

    // Terminal count of a period: clamp 0 to 1, then add the fractional stretch.
    // clamp-1 never exceeds 2^NB_DIV-2, so adding one cannot overflow.
    function automatic logic [NB_DIV-1:0] last_count(input logic [NB_DIV-1:0] div,
                                                      input logic ext);
        logic [NB_DIV-1:0] d;
        d = (div == '0) ? NB_DIV'(1) : div;
        return d - NB_DIV'(1) + NB_DIV'(ext);
    endfunction

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        os_cnt_n  = os_cnt;
        div_act_n = div_act;
        div_sh_n  = div_sh;
        pending_n = o_load_pending;
`ifdef BAUD_GEN_FRAC_EN
        frac_act_n = frac_act;
        frac_sh_n  = frac_sh;
        acc_n      = acc;
        extra_n    = extra;
        carry      = 1'b0;
`endif
        wrap = (state == RUN) && (cnt == last_count(div_act, extra));

        if (state == IDLE || !i_enable) begin
            // Idle or leaving RUN: counters clear and the newest divisor becomes active.
            state_n   = i_enable ? RUN : IDLE;
            cnt_n     = '0;
            os_cnt_n  = '0;
            pending_n = 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            acc_n   = '0;
            extra_n = 1'b0;
`endif
            if (i_div_load) begin
                div_act_n = i_div_int;
                div_sh_n  = i_div_int;
`ifdef BAUD_GEN_FRAC_EN
                frac_act_n = i_div_frac;
                frac_sh_n  = i_div_frac;
`endif
            end else if (o_load_pending) begin
                div_act_n = div_sh;
`ifdef BAUD_GEN_FRAC_EN
                frac_act_n = frac_sh;
`endif
            end
        end else begin
            if (wrap) begin
                cnt_n    = '0;
                os_cnt_n = (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
`ifdef BAUD_GEN_FRAC_EN
                {carry, acc_n} = {1'b0, acc} + {1'b0, frac_act};
                extra_n        = carry;
`endif
                if (o_load_pending) begin
                    div_act_n = div_sh;
                    pending_n = 1'b0;
`ifdef BAUD_GEN_FRAC_EN
                    frac_act_n = frac_sh;
`endif
                end
            end else begin
                cnt_n = cnt + NB_DIV'(1);
            end
            // A load on the wrap cycle lands after the swap above, so it waits one more period.
            if (i_div_load) begin
                div_sh_n  = i_div_int;
                pending_n = 1'b1;
`ifdef BAUD_GEN_FRAC_EN
                frac_sh_n = i_div_frac;
`endif
            end
        end

        tick_n = (state_n == RUN) && (cnt_n == last_count(div_act_n, extra_n));
        bit_n  = tick_n && (os_cnt_n == OS_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            cnt            <= '0;
            os_cnt         <= '0;
            div_act        <= NB_DIV'(DEFAULT_DIV);
            div_sh         <= '0;
            o_load_pending <= 1'b0;
            o_tick         <= 1'b0;
            o_bit_tick     <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            frac_act <= '0;
            frac_sh  <= '0;
            acc      <= '0;
            extra    <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            os_cnt         <= os_cnt_n;
            div_act        <= div_act_n;
            div_sh         <= div_sh_n;
            o_load_pending <= pending_n;
            o_tick         <= tick_n;
            o_bit_tick     <= bit_n;
`ifdef BAUD_GEN_FRAC_EN
            frac_act <= frac_act_n;
            frac_sh  <= frac_sh_n;
            acc      <= acc_n;
            extra    <= extra_n;
`endif
        end
    end

endmodule
